nibble_serial_adder_ctrl: RTL

Sequencer that computes WIDTH-bit add/subtract by stepping a single 4-bit carry-lookahead slice across the operands, one nibble per clock, LSB nibble first. Carry ripples between nibbles through a registered carry flop. It trades latency for area so wide operands can share one lookahead slice in the lab datapath. Start/busy/done handshake; result, carry-out and signed overflow are held until the next accepted operation.

---
 rtl/nibble_serial_adder_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds or subtracts two WIDTH-bit operands with a single 4-bit carry-lookahead
// slice. The slice is stepped across the operands one nibble per clock,
// starting with the LSB nibble. A registered carry flop passes the carry from
// one nibble to the next. The result, carry-out and signed overflow stay
// valid from the done pulse until the next accepted operation.
//
// WIDTH must be a multiple of 4 and at least 4.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start_i  request a new operation (sampled only in IDLE)
//   sub_i    0: a+b+cin, 1: a-b-cin (latched at accept)
//   a_i      operand A (latched at accept)
//   b_i      operand B (latched at accept)
//   cin_i    carry/borrow in (latched at accept)
//   busy_o   high while nibbles are being processed
//   done_o   one-cycle pulse when the result is valid
//   sum_o    result register
//   cout_o   carry out of the MSB (for subtract: 1 = no borrow)
//   ovf_o    two's-complement overflow
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// RUN   | one nibble of the operands is processed per clock
// DONE  | result valid, done pulse for one cycle

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_s;
    logic [4:0] c;

    // Select the current nibble. The loop form keeps the index compare
    // exactly IDXW bits wide for every WIDTH.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDXW'(n)) begin
                nib_a = op_a_q[4*n +: 4];
                nib_b = op_b_q[4*n +: 4];
            end
        end
    end

    // 4-bit lookahead slice. Every carry is a flat sum of products of g, p and
    // the incoming carry, so no carry ripples inside the slice.
    always_comb begin
        nib_g = nib_a & nib_b;
        nib_p = nib_a | nib_b;
        c[0]  = carry_q;
        c[1]  = nib_g[0] | (nib_p[0] & c[0]);
        c[2]  = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & c[0]);
        c[3]  = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
              | (nib_p[2] & nib_p[1] & nib_p[0] & c[0]);
        c[4]  = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
              | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
              | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & c[0]);
        nib_s = nib_a ^ nib_b ^ c[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Subtract is done as a + ~b + ~cin.
                    op_a_d  = a_i;
                    op_b_d  = sub_i ? ~b_i : b_i;
                    carry_d = cin_i ^ sub_i;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIB; n++) begin
                    if (idx_q == IDXW'(n)) begin
                        sum_d[4*n +: 4] = nib_s;
                    end
                end
                carry_d = c[4];
                if (idx_q == IDXW'(NIB - 1)) begin
                    idx_d   = '0;
                    cout_d  = c[4];
                    ovf_d   = c[3] ^ c[4];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule
